// File: rtl/fcs_checker.sv
// Receive-side serial CRC-16 checker (x^16+x^12+x^5+1, init 0, MSB first).
// Runs the LFSR over payload + 16 FCS bits and flags the frame good or bad.
module fcs_checker #(
    parameter int DATA_BITS = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        frame_start,
    input  logic        bit_valid,
    input  logic        data_i,
    output logic        busy,
    output logic        done,
    output logic        crc_ok,
    output logic        crc_err,
    output logic [15:0] fcs_calc
);
    localparam int CNT_W = $clog2(DATA_BITS + 17);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_FCS  = CNT_W'(DATA_BITS + 16);

    typedef enum logic [1:0] {IDLE, DATA, CHECK, DONE} state_t;

    state_t           state_reg;
    state_t           state_eff;
    logic [0:15]      lfsr_reg;
    logic [0:15]      lfsr_base;
    logic [0:15]      lfsr_next;
    logic [0:15]      fcs_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             fb;
    logic             accept;

    // frame_start overrides whatever is in flight: the cycle behaves as the
    // first DATA cycle of a fresh frame, seeded from a cleared LFSR/counter.
    always_comb begin
        state_eff = frame_start ? DATA : state_reg;
        lfsr_base = frame_start ? 16'h0000 : lfsr_reg;
        cnt_next  = (frame_start ? {CNT_W{1'b0}} : cnt_reg) + CNT_W'(1);
        accept    = bit_valid && ((state_eff == DATA) || (state_eff == CHECK));
    end

    assign fb = lfsr_base[0] ^ data_i;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_lfsr
            if (gi == 15) begin : g_fb
                assign lfsr_next[gi] = fb;
            end else if ((gi == 3) || (gi == 10)) begin : g_tap
                assign lfsr_next[gi] = lfsr_base[gi+1] ^ fb;
            end else begin : g_shift
                assign lfsr_next[gi] = lfsr_base[gi+1];
            end
            // lfsr[0] is the first FCS bit on the wire, hence the MSB
            assign fcs_calc[15-gi] = fcs_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            lfsr_reg  <= '0;
            cnt_reg   <= '0;
            fcs_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            crc_ok    <= 1'b0;
            crc_err   <= 1'b0;
        end else begin
            done      <= 1'b0;
            state_reg <= state_eff;

            if (accept) begin
                lfsr_reg <= lfsr_next;
                cnt_reg  <= cnt_next;
            end else if (frame_start) begin
                lfsr_reg <= '0;
                cnt_reg  <= '0;
            end

            if (frame_start) begin
                busy    <= 1'b1;
                crc_ok  <= 1'b0;
                crc_err <= 1'b0;
            end

            case (state_eff)
                DATA: begin
                    if (accept && (cnt_next == LAST_DATA)) begin
                        fcs_reg   <= lfsr_next;
                        state_reg <= CHECK;
                    end
                end
                CHECK: begin
                    if (accept && (cnt_next == LAST_FCS)) begin
                        crc_ok    <= (lfsr_next == 16'h0000);
                        crc_err   <= (lfsr_next != 16'h0000);
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= DONE;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fcs_checker.sv
// Scoreboard bench for fcs_checker: two instances (8- and 72-bit payloads),
// expected results from a polynomial-division CRC model.
`timescale 1ns/1ps
module tb_fcs_checker;
    typedef bit bitq_t[$];
    typedef struct {
        logic [15:0] fcs;
        logic        ok;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        frame_start = 1'b0;
    logic        bit_valid = 1'b0;
    logic        data_i = 1'b0;
    int          sel = 0;
    logic        fs8, fs72;
    logic        busy8, done8, ok8, err8;
    logic        busy72, done72, ok72, err72;
    logic [15:0] fcs8, fcs72;

    exp_t q8[$];
    exp_t q72[$];
    int   tests = 0;
    int   fails = 0;
    bit   stim_done = 0;

    assign fs8  = frame_start && (sel == 0);
    assign fs72 = frame_start && (sel == 1);

    always #5 clk = ~clk;

    fcs_checker #(.DATA_BITS(8)) dut8 (
        .clk(clk), .rstn(rstn), .frame_start(fs8), .bit_valid(bit_valid),
        .data_i(data_i), .busy(busy8), .done(done8), .crc_ok(ok8),
        .crc_err(err8), .fcs_calc(fcs8)
    );

    fcs_checker #(.DATA_BITS(72)) dut72 (
        .clk(clk), .rstn(rstn), .frame_start(fs72), .bit_valid(bit_valid),
        .data_i(data_i), .busy(busy72), .done(done72), .crc_ok(ok72),
        .crc_err(err72), .fcs_calc(fcs72)
    );

    // Remainder of the bit polynomial modulo G(x) = x^16+x^12+x^5+1
    function automatic logic [15:0] poly_mod(input bitq_t bits);
        logic [16:0] r = '0;
        foreach (bits[i]) begin
            r = {r[15:0], bits[i]};
            if (r[16]) r = r ^ 17'h11021;
        end
        return r[15:0];
    endfunction

    function automatic logic [15:0] crc_of(input bitq_t pay);
        bitq_t aug = pay;
        repeat (16) aug.push_back(1'b0);
        return poly_mod(aug);
    endfunction

    function automatic bitq_t val_bits(input logic [71:0] v, input int n);
        bitq_t q;
        for (int i = n - 1; i >= 0; i--) q.push_back(v[i]);
        return q;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Sends frame bits; stop_after < 0 sends the whole frame and records the
    // expected result, otherwise the frame is abandoned after stop_after bits.
    task automatic send_frame(input int s, input bitq_t pay, input logic [15:0] fcs,
                              input int gap_max, input bit fs_with_bit, input int stop_after);
        bitq_t all = pay;
        bitq_t fb  = val_bits({56'h0, fcs}, 16);
        exp_t  e;
        int    n;
        int    idx = 0;
        foreach (fb[i]) all.push_back(fb[i]);
        n = (stop_after < 0) ? all.size() : stop_after;
        e.fcs = crc_of(pay);
        e.ok  = (poly_mod(all) == 16'h0000);
        sel = s;
        if (stop_after < 0) begin
            if (s == 0) q8.push_back(e);
            else        q72.push_back(e);
        end
        frame_start = 1'b1;
        if (fs_with_bit && n > 0) begin
            bit_valid = 1'b1;
            data_i    = all[0];
            idx       = 1;
        end
        @(posedge clk); #1;
        frame_start = 1'b0;
        bit_valid   = 1'b0;
        while (idx < n) begin
            repeat ($urandom_range(0, gap_max)) begin
                data_i = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            bit_valid = 1'b1;
            data_i    = all[idx];
            @(posedge clk); #1;
            bit_valid = 1'b0;
            idx++;
        end
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((q8.size() + q72.size()) != 0 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, 32'(q8.size() + q72.size()), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (ok8 && err8) begin
                    tests++; fails++;
                    $display("FAIL dut8_excl: crc_ok and crc_err both high");
                end
                if (ok72 && err72) begin
                    tests++; fails++;
                    $display("FAIL dut72_excl: crc_ok and crc_err both high");
                end
                if (done8) begin
                    tests++;
                    if (q8.size() == 0) begin
                        fails++;
                        $display("FAIL dut8_done: unexpected done, fcs_calc=%h", fcs8);
                    end else begin
                        e = q8.pop_front();
                        $display("[TB] dut8 frame: fcs_calc=%h crc_ok=%0b crc_err=%0b", fcs8, ok8, err8);
                        if ({busy8, ok8, err8, fcs8} !== {1'b0, e.ok, ~e.ok, e.fcs}) begin
                            fails++;
                            $display("FAIL dut8_frame: got busy=%0b ok=%0b err=%0b fcs=%h, expected busy=0 ok=%0b err=%0b fcs=%h",
                                     busy8, ok8, err8, fcs8, e.ok, ~e.ok, e.fcs);
                        end
                    end
                end
                if (done72) begin
                    tests++;
                    if (q72.size() == 0) begin
                        fails++;
                        $display("FAIL dut72_done: unexpected done, fcs_calc=%h", fcs72);
                    end else begin
                        e = q72.pop_front();
                        $display("[TB] dut72 frame: fcs_calc=%h crc_ok=%0b crc_err=%0b", fcs72, ok72, err72);
                        if ({busy72, ok72, err72, fcs72} !== {1'b0, e.ok, ~e.ok, e.fcs}) begin
                            fails++;
                            $display("FAIL dut72_frame: got busy=%0b ok=%0b err=%0b fcs=%h, expected busy=0 ok=%0b err=%0b fcs=%h",
                                     busy72, ok72, err72, fcs72, e.ok, ~e.ok, e.fcs);
                        end
                    end
                end
            end
        end
    endtask

    task automatic stimulus();
        bitq_t p1  = val_bits(72'h1, 8);
        bitq_t p0  = val_bits(72'h0, 8);
        bitq_t pa  = val_bits(72'h313233343536373839, 72);
        bitq_t pr;
        logic [15:0] f;

        // Reset state
        rstn = 1'b0;
        idle(3);
        check("reset_dut8",  {11'h0, busy8,  done8,  ok8,  err8,  fcs8},  32'h0);
        check("reset_dut72", {11'h0, busy72, done72, ok72, err72, fcs72}, 32'h0);
        rstn = 1'b1;
        idle(2);

        // bit_valid in IDLE must not start anything
        repeat (10) begin
            bit_valid = 1'($urandom_range(0, 1));
            data_i    = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        bit_valid = 1'b0;
        check("idle_ignore", {30'h0, busy8, busy72}, 32'h0);

        // All-zero frame and the 0x01 frame
        send_frame(0, p0, 16'h0000, 0, 0, -1);
        wait_drain("t1_drain");
        send_frame(0, p1, 16'h1021, 0, 0, -1);
        wait_drain("t2_drain");
        check("t2_fcs", 32'(fcs8), 32'h1021);
        idle(3);
        check("t2_hold", {30'h0, ok8, err8}, 32'h2);

        // Check string, contiguous then with gaps
        send_frame(1, pa, 16'h31C3, 0, 0, -1);
        wait_drain("t3_drain");
        check("t3_fcs", 32'(fcs72), 32'h31C3);
        send_frame(1, pa, 16'h31C3, 3, 0, -1);
        wait_drain("t3_gap_drain");
        check("t3_gap_ok", {31'h0, ok72}, 32'h1);

        // Corrupted FCS
        send_frame(0, p1, 16'h1020, 1, 0, -1);
        wait_drain("t4_drain");
        check("t4_err", {14'h0, ok8, err8, fcs8}, {14'h0, 2'b01, 16'h1021});

        // Abort after 5 payload bits, then a restart with bit on frame_start
        send_frame(0, p1, 16'h1021, 0, 0, 5);
        check("t5_busy_clear", {29'h0, busy8, ok8, err8}, 32'h4);
        send_frame(0, p1, 16'h1021, 0, 1, -1);
        wait_drain("t5_drain");

        // Back-to-back: second frame_start lands in the DONE cycle
        send_frame(0, p1, 16'h1021, 0, 0, -1);
        send_frame(0, p0, 16'h0001, 0, 0, -1);
        wait_drain("b2b_drain");

        // Asynchronous reset in the middle of CHECK
        send_frame(0, p1, 16'h1021, 0, 0, 13);
        check("t6_busy", {31'h0, busy8}, 32'h1);
        #2 rstn = 1'b0;
        #1 check("t6_async", {11'h0, busy8, done8, ok8, err8, fcs8}, 32'h0);
        idle(2);
        rstn = 1'b1;
        idle(1);
        send_frame(0, p1, 16'h1021, 0, 0, -1);
        wait_drain("t6_drain");

        // Randomized frames on both widths
        for (int n = 0; n < 40; n++) begin
            int s = ($urandom_range(0, 4) == 0) ? 1 : 0;
            pr = {};
            for (int i = 0; i < (s == 1 ? 72 : 8); i++) pr.push_back(1'($urandom_range(0, 1)));
            f = ($urandom_range(0, 1) == 1) ? crc_of(pr) : 16'($urandom);
            send_frame(s, pr, f, 2, 1'($urandom_range(0, 1)), -1);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
        end
        wait_drain("rand_drain");
        stim_done = 1;
    endtask

    initial begin
        fork
            monitor();
            stimulus();
            begin
                #200000;
                tests++; fails++;
                $display("FAIL timeout: stimulus did not complete");
            end
        join_any
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
